instr_encoder: RTL and testbench

//  Program-loader side of the ISA: takes decoded fields (op, pred, rd, rs1, rs2, funct4, imm),

---
 rtl/instr_pkg.sv | 55 +++++
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_pack.sv | 58 +++++
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared ISA constants for the instruction encoder: opcodes, function codes,
// field bit positions and the encoder FSM state type.
package instr_pkg;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ITYPE = 3'd1;
  localparam logic [2:0] OP_MTYPE = 3'd2;
  localparam logic [2:0] OP_CTYPE = 3'd3;
  localparam logic [2:0] OP_PTYPE = 3'd4;
  localparam logic [2:0] OP_FTYPE = 3'd5;

  // Integer ALU function codes; R-type accepts ADD..ABS, I-type a subset plus SLLI.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SGT  = 4'd5;
  localparam logic [3:0] ALU_SEQ  = 4'd6;
  localparam logic [3:0] ALU_SNEZ = 4'd7;
  localparam logic [3:0] ALU_MIN  = 4'd8;
  localparam logic [3:0] ALU_ABS  = 4'd9;
  localparam logic [3:0] ALU_SLLI = 4'd10;

  localparam logic [3:0] FALU_FADD = 4'd0;
  localparam logic [3:0] FALU_FSUB = 4'd1;
  localparam logic [3:0] FALU_FMUL = 4'd2;
  localparam logic [3:0] FALU_FDIV = 4'd3;
  localparam logic [3:0] FALU_FMIN = 4'd4;
  localparam logic [3:0] FALU_FMAX = 4'd5;

  localparam logic [3:0] MEM_LOAD  = 4'd0;
  localparam logic [3:0] MEM_STORE = 4'd1;

  localparam logic [2:0] C_JUMP = 3'b000;
  localparam logic [2:0] C_BEQ  = 3'b001;
  localparam logic [2:0] C_BNE  = 3'b010;
  localparam logic [2:0] C_CALL = 3'b011;
  localparam logic [2:0] C_RSV0 = 3'b100;
  localparam logic [2:0] C_RSV1 = 3'b101;
  localparam logic [2:0] C_RET  = 3'b110;
  localparam logic [2:0] C_EXIT = 3'b111;

  localparam int unsigned OP_LSB     = 29;
  localparam int unsigned PRED_BIT   = 28;
  localparam int unsigned RD_LSB     = 23;
  localparam int unsigned RS1_LSB    = 18;
  localparam int unsigned IMM_HI_LSB = 14;
  localparam int unsigned F4_LSB     = 10;
  localparam int unsigned RS2_LSB    = 5;
  localparam int unsigned IMM_LO_LSB = 0;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} enc_state_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Loader-side bundle channel, imem write port and session status of the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 10
) ();
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic                  in_pred;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [3:0]            in_funct4;
  logic [13:0]           in_imm;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ack;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output start, in_valid, in_op, in_pred, in_rd, in_rs1, in_rs2, in_funct4, in_imm, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, err, count
  );

  modport slave (
    input  start, in_valid, in_op, in_pred, in_rd, in_rs1, in_rs2, in_funct4, in_imm, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata, done, err, count
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational field-to-word packer with a legality flag and EXIT detect;
// the exact inverse of the control unit's field split.
module instr_pack
  import instr_pkg::*;
(
  input  logic [2:0]  op,
  input  logic        pred,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [3:0]  funct4,
  input  logic [13:0] imm,
  output logic [31:0] word,
  output logic        legal,
  output logic        is_exit
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 3]  = op;
    word[PRED_BIT]     = pred;
    word[RD_LSB +: 5]  = rd;
    word[RS1_LSB +: 5] = rs1;
    case (op)
      OP_RTYPE, OP_FTYPE: begin
        word[F4_LSB +: 4]  = funct4;
        word[RS2_LSB +: 5] = rs2;
      end
      OP_CTYPE: begin
        // Bit 13 stays 0: only funct3 is meaningful for control ops.
        word[IMM_HI_LSB +: 4]  = imm[13:10];
        word[IMM_LO_LSB +: 10] = imm[9:0];
        word[F4_LSB +: 3]      = funct4[2:0];
      end
      default: begin
        word[IMM_HI_LSB +: 4]  = imm[13:10];
        word[IMM_LO_LSB +: 10] = imm[9:0];
        word[F4_LSB +: 4]      = funct4;
      end
    endcase
  end

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_RTYPE: legal = (funct4 <= ALU_ABS);
      OP_ITYPE: legal = (funct4 inside {ALU_ADD, ALU_MUL, ALU_DIV, ALU_SLLI});
      OP_MTYPE: legal = (funct4 <= MEM_STORE);
      OP_CTYPE: legal = !(funct4[2:0] inside {C_RSV0, C_RSV1});
      OP_PTYPE: legal = 1'b1;
      OP_FTYPE: legal = (funct4 <= FALU_FMAX);
      default:  legal = 1'b0;
    endcase
  end

  assign is_exit = (op == OP_CTYPE) && (funct4[2:0] == C_EXIT);

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded field bundles into instruction words and writes them sequentially to imem.
// Optional build macro ENC_LEGAL_CHECK_EN rejects illegal bundles instead of packing them.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   Capacity = {1'b1, {ADDR_WIDTH{1'b0}}};

  enc_state_t              state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    exit_q, exit_d;
  logic                    err_q, err_d;

  logic [31:0] packed_word;
  logic        legal;
  logic        legal_ok;
  logic        is_exit;

  instr_pack u_pack (
    .op      (bus.in_op),
    .pred    (bus.in_pred),
    .rd      (bus.in_rd),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .funct4  (bus.in_funct4),
    .imm     (bus.in_imm),
    .word    (packed_word),
    .legal   (legal),
    .is_exit (is_exit)
  );

`ifdef ENC_LEGAL_CHECK_EN
  assign legal_ok = legal;
`else
  assign legal_ok = 1'b1;
  logic unused_legal;
  assign unused_legal = legal;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    exit_d  = exit_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = ACCEPT;
          addr_d  = BaseAddr;
          count_d = '0;
          exit_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          if (count_q == Capacity) begin
            // Memory full: drop the word and end the session.
            err_d   = 1'b1;
            state_d = DONE;
          end else if (!legal_ok) begin
            err_d = 1'b1;
          end else begin
            wdata_d = packed_word;
            exit_d  = is_exit;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          addr_d  = addr_q + 1'b1;
          count_d = count_q + 1'b1;
          state_d = exit_q ? DONE : ACCEPT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= BaseAddr;
      wdata_q <= '0;
      count_q <= '0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCEPT);
  assign bus.mem_we    = (state_q == WRITE);
  assign bus.done      = (state_q == DONE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.count     = count_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized scoreboard bench for instr_encoder with a 4-word memory so overflow is reachable.
module tb_instr_encoder;
  import instr_pkg::*;

  localparam int unsigned AW   = 2;
  localparam int unsigned BASE = 0;
  localparam int          CAP  = 4;
`ifdef ENC_LEGAL_CHECK_EN
  localparam bit LegalChk = 1'b1;
`else
  localparam bit LegalChk = 1'b0;
`endif

  typedef struct {
    int op; int pred; int rd; int rs1; int rs2; int f4; int imm;
  } bundle_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  n_cmp  = 0;
  int  n_fail = 0;
  wr_t exp_q[$];
  int  m_count = 0;
  bit  m_done = 1'b0, m_err = 1'b0, m_active = 1'b0;
  int  ack_mode = 0;
  int  we_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field positions by plain arithmetic.
  function automatic logic [31:0] model_word(input bundle_t b);
    longint w;
    w = longint'(b.op) * (64'd1 << 29) + longint'(b.pred) * (64'd1 << 28)
      + longint'(b.rd) * (64'd1 << 23) + longint'(b.rs1) * (64'd1 << 18);
    if (b.op == 0 || b.op == 5) begin
      w += longint'(b.f4) * 1024 + longint'(b.rs2) * 32;
    end else begin
      w += longint'(b.imm / 1024) * (64'd1 << 14) + longint'(b.imm % 1024);
      w += (b.op == 3) ? longint'(b.f4 % 8) * 1024 : longint'(b.f4) * 1024;
    end
    return w[31:0];
  endfunction

  function automatic bit model_legal(input bundle_t b);
    case (b.op)
      0: return b.f4 <= 9;
      1: return b.f4 inside {0, 2, 3, 10};
      2: return b.f4 <= 1;
      3: return !((b.f4 % 8) inside {4, 5});
      4: return 1'b1;
      5: return b.f4 <= 5;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bundle_t mk(input int op, input int pred, input int rd, input int rs1,
                                 input int rs2, input int f4, input int imm);
    bundle_t b;
    b.op = op; b.pred = pred; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.f4 = f4;
    b.imm = imm & 16'h3fff;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = mk(int'($urandom_range(0, LegalChk ? 7 : 5)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 16383)));
    if (b.op == 3 && b.f4 % 8 == 7 && $urandom_range(0, 3) != 0) b.f4 = 0;
    return b;
  endfunction

  task automatic model_accept(input bundle_t b, input bit use_lit, input logic [31:0] lit);
    wr_t w;
    if (m_count == CAP) begin
      m_err  = 1'b1;
      m_done = 1'b1;
    end else if (LegalChk && !model_legal(b)) begin
      m_err = 1'b1;
    end else begin
      w.addr = AW'(BASE + m_count);
      w.data = use_lit ? lit : model_word(b);
      exp_q.push_back(w);
      m_count++;
      if (b.op == 3 && b.f4 % 8 == 7) m_done = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, 64'(bus.count), 64'(m_count));
    check({tag, ".done"}, 64'(bus.done), 64'(m_done));
    check({tag, ".err"}, 64'(bus.err), 64'(m_err));
    check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(m_active && !m_done));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".in_ready"}, 64'(bus.in_ready), 0);
    check({tag, ".mem_we"}, 64'(bus.mem_we), 0);
    check({tag, ".mem_addr"}, 64'(bus.mem_addr), 64'(BASE));
    check({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 0);
    check({tag, ".done"}, 64'(bus.done), 0);
    check({tag, ".err"}, 64'(bus.err), 0);
    check({tag, ".count"}, 64'(bus.count), 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    if (!m_active || m_done) begin
      m_active = 1'b1; m_done = 1'b0; m_err = 1'b0; m_count = 0;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send(input bundle_t b, input bit use_lit, input logic [31:0] lit,
                      input bit wait_idle, input string tag);
    int t;
    @(negedge clk);
    bus.in_op = 3'(b.op); bus.in_pred = 1'(b.pred); bus.in_rd = 5'(b.rd);
    bus.in_rs1 = 5'(b.rs1); bus.in_rs2 = 5'(b.rs2); bus.in_funct4 = 4'(b.f4);
    bus.in_imm = 14'(b.imm);
    bus.in_valid = 1'b1;
    t = 0;
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus.in_ready) begin
      check({tag, ".accept_timeout"}, 64'(bus.in_ready), 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(b, use_lit, lit);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (wait_idle) begin
      t = 0;
      while (bus.mem_we && t < 100) begin @(negedge clk); t++; end
      if (bus.mem_we) check({tag, ".write_timeout"}, 64'(bus.mem_we), 0);
      check_state(tag);
    end
  endtask

  // Memory side: ack policy is random, fixed 3-cycle delay, or never.
  initial begin
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      we_run = bus.mem_we ? we_run + 1 : 0;
      case (ack_mode)
        0:       bus.mem_ack = 1'($urandom_range(0, 1));
        1:       bus.mem_ack = bus.mem_we && (we_run >= 3);
        default: bus.mem_ack = 1'b0;
      endcase
    end
  end

  // Monitor: every cycle a write is presented it must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.mem_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        check("wr_addr", 64'(bus.mem_addr), 64'(exp_q[0].addr));
        check("wr_data", 64'(bus.mem_wdata), 64'(exp_q[0].data));
        if (bus.mem_ack) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got no finish, expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bundle_t b;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_op = '0; bus.in_pred = 1'b0;
    bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_funct4 = '0; bus.in_imm = '0;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;

    // Reset while a write is stalled: everything returns to reset values, write is dropped.
    ack_mode = 2;
    do_start();
    send(mk(1, 0, 7, 8, 0, 0, 5), 1'b0, '0, 1'b0, "t1");
    check("t1.pending_we", 64'(bus.mem_we), 1);
    #2 rst = 1'b1;
    #1 check_reset("t1.async");
    exp_q.delete();
    m_active = 1'b0; m_done = 1'b0; m_err = 1'b0; m_count = 0;
    @(posedge clk);
    #1 check_reset("t1.edge");
    @(negedge clk);
    rst = 1'b0;
    ack_mode = 0;
    repeat (4) @(negedge clk);
    check("t1.no_we_after", 64'(bus.mem_we), 0);

    // R ADD against a literal encoding, then EXIT.
    do_start();
    send(mk(0, 1, 3, 1, 2, 0, 0), 1'b1,
         {OP_RTYPE, 1'b1, 5'd3, 5'd1, 4'b0, ALU_ADD, 5'd2, 5'b0}, 1'b1, "t2");
    send(mk(3, 0, 0, 0, 0, 7, 0), 1'b0, '0, 1'b1, "t2.exit");

    // Delayed acks; a start mid-session is ignored.
    ack_mode = 1;
    do_start();
    send(mk(1, 0, 4, 5, 9, 0, -1), 1'b0, '0, 1'b1, "t3.i");
    do_start();
    check_state("t3.start_ignored");
    send(mk(2, 1, 6, 2, 0, 1, 'h155), 1'b0, '0, 1'b1, "t3.m");

    // EXIT as third word; bundles afterwards are ignored; start clears done.
    ack_mode = 0;
    send(mk(3, 0, 1, 2, 0, 7, 40), 1'b0, '0, 1'b1, "t4.exit");
    check("t4.count3", 64'(bus.count), 3);
    @(negedge clk);
    bus.in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t4.ignored_ready", 64'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    do_start();
    check_state("t4.restart");

    // Fifth bundle overflows the 4-word memory.
    for (int i = 0; i < 5; i++) send(mk(0, 0, i, i + 1, i + 2, 0, 0), 1'b0, '0, 1'b1, "t5");
    check("t5.err", 64'(bus.err), 1);
    check("t5.done", 64'(bus.done), 1);

`ifdef ENC_LEGAL_CHECK_EN
    do_start();
    send(mk(3, 0, 1, 1, 0, 4, 12), 1'b0, '0, 1'b1, "t6.illegal");
    send(mk(4, 1, 2, 3, 0, 5, 99), 1'b0, '0, 1'b1, "t6.legal");
    send(mk(3, 0, 0, 0, 0, 7, 0), 1'b0, '0, 1'b1, "t6.exit");
`endif

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      do_start();
      for (int k = 0; k < 7; k++) begin
        if (!m_done) begin
          b = rand_bundle();
          send(b, 1'b0, '0, 1'b1, "rand");
        end
      end
      if (!m_done) send(mk(3, 0, 0, 0, 0, 7, 0), 1'b0, '0, 1'b1, "rand.exit");
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
